// File: rtl/ir_frame_ctrl.sv
// ir_frame_ctrl: IR receive-path frame sequencer.
//
// Measures each high interval on the IR line, classifies it as a leader,
// a 1-bit, a 0-bit or a timeout, and assembles NBITS bits MSB-first into a
// frame. The frame is offered downstream with a valid/ready handshake.
//
// Ports:
//   clk_i          single rising-edge clock
//   reset_i        synchronous, active-high reset
//   ir_i           raw asynchronous IR line
//   frame_ready_i  downstream accepts the frame
//   frame_o        assembled frame, MSB = first bit received
//   frame_valid_o  frame available, held until accepted
//   busy_o         high while a frame is being received
//   error_o        one-cycle pulse on a timeout during reception
//   overrun_o      one-cycle pulse when a leader arrives while a frame is pending

module ir_frame_ctrl #(
    parameter int unsigned NBITS         = 32,
    parameter int unsigned ONE_THRESH    = 1000,
    parameter int unsigned LEADER_THRESH = 1800,
    parameter int unsigned TIMEOUT       = 177127
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             ir_i,
    input  logic             frame_ready_i,
    output logic [NBITS-1:0] frame_o,
    output logic             frame_valid_o,
    output logic             busy_o,
    output logic             error_o,
    output logic             overrun_o
);

    localparam int unsigned CntW = $clog2(NBITS + 1);
    localparam logic [31:0] SatVal = 32'(TIMEOUT + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(NBITS - 1);

    typedef enum logic [1:0] {StIdle, StRecv, StValid} state_e;

    // Synchronizer and edge-detect delay
    logic ir_meta_q, ir_s_q, ir_q;

    // Interval counter
    logic [31:0] len_q, len_d;

    state_e            state_q, state_d;
    logic [NBITS-1:0]  shift_q, shift_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [NBITS-1:0]  frame_q, frame_d;
    logic              error_q, error_d;
    logic              overrun_q, overrun_d;

    logic              fall;
    logic              in_range;
    logic              ev_leader;
    logic              ev_bit;
    logic              ev_timeout;
    logic              bit_val;
    logic [NBITS-1:0]  shifted;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ir_meta_q <= 1'b0;
            ir_s_q    <= 1'b0;
            ir_q      <= 1'b0;
        end else begin
            ir_meta_q <= ir_i;
            ir_s_q    <= ir_meta_q;
            ir_q      <= ir_s_q;
        end
    end

    // Saturating at TIMEOUT+1 keeps an endless high from wrapping and
    // re-triggering the timeout.
    always_comb begin
        len_d = 32'd0;
        if (ir_s_q) begin
            len_d = (len_q == SatVal) ? len_q : len_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            len_q <= 32'd0;
        end else begin
            len_q <= len_d;
        end
    end

    // len_q still holds the high-cycle count in the cycle the fall is seen.
    assign fall       = ~ir_s_q & ir_q;
    assign in_range   = (len_q <= TIMEOUT);
    assign ev_leader  = fall && in_range && (len_q > LEADER_THRESH);
    assign ev_bit     = fall && in_range && (len_q <= LEADER_THRESH);
    assign bit_val    = (len_q > ONE_THRESH);
    assign ev_timeout = ir_s_q && (len_q == TIMEOUT);
    assign shifted    = (shift_q << 1) | NBITS'(bit_val);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        error_d   = 1'b0;
        overrun_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ev_leader) begin
                    state_d   = StRecv;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                end
            end
            StRecv: begin
                if (ev_timeout) begin
                    error_d   = 1'b1;
                    state_d   = StIdle;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                end else if (ev_leader) begin
                    shift_d   = '0;
                    bit_cnt_d = '0;
                end else if (ev_bit) begin
                    shift_d = shifted;
                    if (bit_cnt_q == LastBit) begin
                        frame_d   = shifted;
                        bit_cnt_d = '0;
                        state_d   = StValid;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end
            end
            StValid: begin
                // The pending frame wins; a new leader is only reported.
                if (ev_leader) begin
                    overrun_d = 1'b1;
                end
                if (frame_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            error_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            error_q   <= error_d;
            overrun_q <= overrun_d;
        end
    end

    assign frame_o       = frame_q;
    assign frame_valid_o = (state_q == StValid);
    assign busy_o        = (state_q == StRecv);
    assign error_o       = error_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_ir_frame_ctrl.sv
// Testbench for ir_frame_ctrl with scaled-down thresholds so that timeouts
// and full frames fit in a short run. Expected behaviour comes from an
// interval-level model: each high length is classified arithmetically and
// applied to a small receiver state held as a bit queue.

module tb_ir_frame_ctrl;

    localparam int unsigned NB  = 12;
    localparam int unsigned ONE = 20;
    localparam int unsigned LDR = 36;
    localparam int unsigned TO  = 100;
    localparam int unsigned GAP = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          ir;
    logic          ready;
    logic [NB-1:0] frame;
    logic          frame_valid;
    logic          busy;
    logic          error;
    logic          overrun;

    ir_frame_ctrl #(
        .NBITS         (NB),
        .ONE_THRESH    (ONE),
        .LEADER_THRESH (LDR),
        .TIMEOUT       (TO)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .ir_i          (ir),
        .frame_ready_i (ready),
        .frame_o       (frame),
        .frame_valid_o (frame_valid),
        .busy_o        (busy),
        .error_o       (error),
        .overrun_o     (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Pulse monitors: count high cycles of the one-cycle outputs.
    int err_cyc = 0;
    int ovr_cyc = 0;
    always @(negedge clk) begin
        if (error)   err_cyc = err_cyc + 1;
        if (overrun) ovr_cyc = ovr_cyc + 1;
    end

    // Reference model: 0 = idle, 1 = receiving, 2 = frame pending
    int            m_state;
    bit            m_bits[$];
    logic [NB-1:0] m_frame;
    int            exp_err;
    int            exp_ovr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_interval(input int unsigned h);
        logic [NB-1:0] f;
        if (h > TO) begin
            if (m_state == 1) begin
                exp_err++;
                m_state = 0;
            end
        end else if (h > LDR) begin
            if (m_state == 0 || m_state == 1) begin
                m_state = 1;
                m_bits.delete();
            end else begin
                exp_ovr++;
            end
        end else if (m_state == 1) begin
            m_bits.push_back(h > ONE);
            if (m_bits.size() == NB) begin
                f = '0;
                foreach (m_bits[i]) f[NB-1-i] = m_bits[i];
                m_frame = f;
                m_state = 2;
            end
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".busy"},    64'(busy),        64'(m_state == 1));
        chk({tag, ".valid"},   64'(frame_valid), 64'(m_state == 2));
        chk({tag, ".frame"},   64'(frame),       64'(m_frame));
        chk({tag, ".err"},     64'(err_cyc),     64'(exp_err));
        chk({tag, ".overrun"}, 64'(ovr_cyc),     64'(exp_ovr));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int unsigned h, input string tag);
        ir = 1'b1;
        cyc(h);
        ir = 1'b0;
        cyc(GAP);
        model_interval(h);
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic send_frame(input logic [NB-1:0] v, input string tag);
        send(LDR + 4, {tag, ".ldr"});
        for (int i = NB - 1; i >= 0; i--) begin
            send(v[i] ? ONE + 8 : ONE - 8, tag);
        end
    endtask

    task automatic accept(input string tag);
        chk({tag, ".pre_valid"}, 64'(frame_valid), 64'd1);
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
        m_state = 0;
        @(negedge clk);
        chk({tag, ".post_valid"}, 64'(frame_valid), 64'd0);
        chk({tag, ".post_busy"},  64'(busy),        64'd0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        m_state = 0;
        m_frame = '0;
        m_bits.delete();
        @(negedge clk);
        chk({tag, ".frame"},   64'(frame),       64'd0);
        chk({tag, ".valid"},   64'(frame_valid), 64'd0);
        chk({tag, ".busy"},    64'(busy),        64'd0);
        chk({tag, ".err"},     64'(error),       64'd0);
        chk({tag, ".overrun"}, 64'(overrun),     64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [NB-1:0] v;
        int unsigned   h;
        reset   = 1'b1;
        ir      = 1'b0;
        ready   = 1'b0;
        m_state = 0;
        m_frame = '0;
        exp_err = 0;
        exp_ovr = 0;
        cyc(3);
        reset = 1'b0;
        @(negedge clk);
        check_state("reset");

        // Basic frame with precise last-bit-to-valid latency
        send(LDR + 4, "basic.ldr");
        chk("basic.busy_recv", 64'(busy), 64'd1);
        for (int i = 0; i < NB - 1; i++) send((i % 2 == 0) ? ONE + 10 : ONE - 10, "basic");
        ir = 1'b1;
        cyc(ONE - 10);
        ir = 1'b0;
        cyc(2);
        @(negedge clk);
        chk("basic.lat_valid0", 64'(frame_valid), 64'd0);
        chk("basic.lat_busy1",  64'(busy),        64'd1);
        @(negedge clk);
        chk("basic.lat_valid1", 64'(frame_valid), 64'd1);
        chk("basic.lat_busy0",  64'(busy),        64'd0);
        cyc(GAP);
        model_interval(ONE - 10);
        @(negedge clk);
        check_state("basic.done");
        chk("basic.aaa", 64'(frame), 64'(12'hAAA));
        accept("basic.acc");

        // Threshold boundaries, including a restart by a minimal leader
        send(LDR + 1, "thr.ldr");
        send(ONE, "thr.one");
        send(ONE + 1, "thr.one1");
        send(LDR, "thr.ldr_bit");
        send(LDR + 1, "thr.restart");
        for (int i = 0; i < NB; i++) begin
            h = (i % 3 == 0) ? ONE : ((i % 3 == 1) ? ONE + 1 : LDR);
            send(h, "thr.bits");
        end
        chk("thr.frame", 64'(frame), 64'(12'h6DB));
        accept("thr.acc");

        // Timeout during reception: error exactly at high-cycle TO+1
        send(LDR + 4, "to.ldr");
        for (int i = 0; i < 5; i++) send(ONE + 5, "to.bits");
        ir = 1'b1;
        cyc(TO + 2);
        @(negedge clk);
        chk("to.err_before", 64'(error), 64'd0);
        @(negedge clk);
        chk("to.err_pulse", 64'(error), 64'd1);
        @(negedge clk);
        chk("to.err_after", 64'(error), 64'd0);
        chk("to.idle", 64'(busy), 64'd0);
        cyc(2 * TO);
        ir = 1'b0;
        cyc(GAP);
        model_interval(4 * TO);
        @(negedge clk);
        check_state("to.done");
        send_frame(12'h5C3, "to.next");
        accept("to.next_acc");

        // Overrun: leader while a frame is pending
        send_frame(12'h39E, "ovr.frame");
        send(LDR + 4, "ovr.leader");
        accept("ovr.acc");

        // Reset mid-reception and while pending
        send(LDR + 4, "rst.ldr");
        for (int i = 0; i < 6; i++) send(ONE + 3, "rst.bits");
        do_reset("rst.mid");
        send_frame(12'h0F1, "rst.next");
        do_reset("rst.valid");
        send_frame(12'hB44, "rst.again");
        accept("rst.acc");

        // Idle noise: bits without a leader
        for (int i = 0; i < 6; i++) send($urandom_range(1, LDR), "noise");

        // Randomised frames with occasional noise and overruns
        for (int f = 0; f < 20; f++) begin
            send($urandom_range(LDR + 1, TO), "rnd.ldr");
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 24) == 0) begin
                    if ($urandom_range(0, 1) == 0) h = $urandom_range(TO + 1, TO + 20);
                    else h = $urandom_range(LDR + 1, TO);
                end else if ($urandom_range(0, 1) == 0) begin
                    h = $urandom_range(1, ONE);
                end else begin
                    h = $urandom_range(ONE + 1, LDR);
                end
                send(h, "rnd.iv");
            end
            if (m_state == 2) begin
                if ($urandom_range(0, 1) == 0) send($urandom_range(LDR + 1, TO), "rnd.ovr");
                accept("rnd.acc");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ir_frame_ctrl.md
# ir_frame_ctrl

Sequencing controller for the IR receive path. It measures the high intervals on the `IR` line and classifies each one as a leader, a 1-bit or a 0-bit, or flags a timeout. It assembles `NBITS` bits MSB-first into a frame and hands the frame downstream with a valid/ready handshake. It sits between the raw IR input pin and the command decoder, and replaces free-running threshold flags with a framed, error-checked word.

## Interface
- `NBITS`, 32: bits per frame, range 1..64.
- `ONE_THRESH`, 1000: an interval longer than this many cycles is a 1-bit; otherwise it is a 0-bit.
- `LEADER_THRESH`, 1800: an interval longer than this is a leader. Requires `ONE_THRESH < LEADER_THRESH`.
- `TIMEOUT`, 177127: a high interval longer than this is a timeout. Requires `LEADER_THRESH < TIMEOUT`.
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `IR` in 1: raw asynchronous IR line. A high interval is the measured quantity.
- `frame_ready` in 1: downstream accepts the frame.
- `frame` out NBITS: assembled frame, MSB = first bit received.
- `frame_valid` out 1: frame available, held until accepted.
- `busy` out 1: high while in RECV.
- `error` out 1: one-cycle pulse on a timeout during RECV.
- `overrun` out 1: one-cycle pulse when a leader arrives while in VALID.

## Operation
- **Input sync:** 2-flop synchronizer gives `ir_s`; `ir_q` is the one-cycle-delayed `ir_s`.
- **Interval counter:** 32-bit.
  - Cleared while `ir_s`=0.
  - Increments each cycle while `ir_s`=1, saturating at `TIMEOUT+1`.
  - Count at the falling edge equals the number of high cycles.
- **Interval end:** `ir_s`=0 and `ir_q`=1. The registered count `len` is classified:
  - `len > TIMEOUT`: ignored, no event.
  - `len > LEADER_THRESH`: LEADER.
  - `len > ONE_THRESH`: BIT1.
  - otherwise: BIT0.
- **Timeout event:** fires in the cycle the counter steps from `TIMEOUT` to `TIMEOUT+1`. At most once per interval.
- **FSM states:** IDLE, RECV, VALID.
  - **IDLE:** LEADER → RECV with shift register and `bit_cnt` cleared. BIT0/BIT1 and timeout are ignored.
  - **RECV:**
    - BIT0/BIT1: shift left, insert the bit at the LSB, `bit_cnt`+1.
    - When the `NBITS`-th bit is shifted: load `frame` from the shifted value and go to VALID.
    - LEADER: restart reception (clear shift register and `bit_cnt`, stay in RECV, no error).
    - Timeout: pulse `error`, go to IDLE, partial bits discarded.
  - **VALID:**
    - `frame_valid`=1. `frame` is stable.
    - `frame_ready`=1 → IDLE.
    - All interval events are ignored, except LEADER, which pulses `overrun`. The state stays VALID and the frame is unchanged.
- `frame_ready` outside VALID has no effect.
- `bit_cnt` width is `$clog2(NBITS+1)`.

## Timing
- **Reset values:** `frame`=0, `frame_valid`=0, `busy`=0, `error`=0, `overrun`=0, counter=0, state IDLE. Synchronizer flops reset to 0.
- **Reset mid-frame:** the partial frame is lost, and a pending `frame_valid` drops the next cycle.
- **IR edge to event:** an `IR` edge reaches `ir_s` 2 cycles later. The classification event occurs in the cycle the falling edge is detected.
- **Last bit to valid:** `frame_valid` and `busy`=0 are asserted on the clock edge after the cycle in which the last bit's falling edge is detected.
- **Handshake:** the transfer occurs on a rising edge with `frame_valid`=1 and `frame_ready`=1. `frame_valid` is 0 from the next cycle, with state IDLE.
- **Back-to-back frames:**
  - A leader that ends in the transfer cycle is seen in VALID: it pulses `overrun` and that frame is missed.
  - A leader that ends one cycle later is accepted.
- **`error` and `overrun`:** each is asserted exactly one cycle, registered.
- **Counter saturation:** prevents wrap-around. An infinitely long high line produces a single timeout.

## Test plan
- **Basic frame:** reset for 3 cycles, then 2000 high / 10 low, then 32 intervals alternating 1500 high and 500 high, each followed by 10 low. Expect `frame`=0xAAAAAAAA, `frame_valid` rising 1 cycle after the last falling-edge detection, `busy` high during RECV. `frame_ready`=1 → `frame_valid` low the next cycle.
- **Thresholds:** intervals of exactly 1000 → bit 0 and 1001 → bit 1. 1800 → bit 1 and 1801 → leader (restarts RECV, `bit_cnt`=0). Expect `frame` bits to match.
- **Timeout:** leader, 5 bits, then `IR` held high 200000 cycles. Expect one `error` pulse at high-cycle 177128, state IDLE, no `frame_valid`. A following full frame decodes correctly.
- **Overrun:** complete frame with `frame_ready`=0, then send a leader. Expect a 1-cycle `overrun`, `frame` unchanged, `frame_valid` held. Then assert `frame_ready` → `frame_valid` drops.
- **Reset mid-operation:** assert `reset` after 16 bits, and separately while in VALID. Expect all outputs 0 the next cycle. The next full frame decodes correctly.
- **Idle noise:** BIT0/BIT1 intervals with no leader in IDLE. Expect no `busy`, no `frame_valid`, no `error`.
